// File: rtl/alu_pkg.sv
// Shared types and widths for the shared-ALU controller and its datapath.
package alu_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        OP_SUB  = 3'b000,
        OP_ADD  = 3'b001,
        OP_MUL  = 3'b010,
        OP_DIV3 = 3'b011,
        OP_AND  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_INV  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } ctrl_state_t;

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Combinational ALU shared by both requesters; the unsupported code yields zero.
module ALU
    import alu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  alu_op_t      Op,
    output logic [W-1:0] Result,
    output logic         Zero,
    output logic         Carry,
    output logic         OverFlow,
    output logic         Negative
);

    localparam logic [W-1:0] THREE = W'(3);

    logic [W:0]     w_wide;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_result;
    logic           w_carry;
    logic           w_ovf;

    // Evaluate the selected operation; carry/overflow only mean something for the arithmetic ops
    always_comb begin
        w_wide   = '0;
        w_prod   = '0;
        w_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (Op)
            OP_SUB: begin
                w_wide   = {1'b0, A} - {1'b0, B};
                w_result = w_wide[W-1:0];
                w_carry  = w_wide[W];
                w_ovf    = (A[W-1] != B[W-1]) && (w_result[W-1] != A[W-1]);
            end
            OP_ADD: begin
                w_wide   = {1'b0, A} + {1'b0, B};
                w_result = w_wide[W-1:0];
                w_carry  = w_wide[W];
                w_ovf    = (A[W-1] == B[W-1]) && (w_result[W-1] != A[W-1]);
            end
            OP_MUL: begin
                w_prod   = {{W{1'b0}}, A} * {{W{1'b0}}, B};
                w_result = w_prod[W-1:0];
                w_carry  = |w_prod[2*W-1:W];
            end
            OP_DIV3: w_result = A / THREE;
            OP_AND:  w_result = A & B;
            OP_SHL: begin
                w_result = {A[W-2:0], 1'b0};
                w_carry  = A[W-1];
            end
            OP_SHR: begin
                w_result = {1'b0, A[W-1:1]};
                w_carry  = A[0];
            end
            default: w_result = '0;
        endcase
    end

    assign Result   = w_result;
    assign Zero     = (w_result == '0);
    assign Carry    = w_carry;
    assign OverFlow = w_ovf;
    assign Negative = w_result[W-1];

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter sharing one ALU between two requesters, with a tagged,
// back-pressured response channel and saturating per-requester completion counters.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2:0]        req_op0,
    input  logic [2:0]        req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt0,
    output logic [CNT_W-1:0]  done_cnt1
);

    ctrl_state_t       r_state;
    ctrl_state_t       w_nextState;
    logic              r_rr;
    logic              w_grant;
    logic              w_handshake;
    alu_op_t           r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_id;
    logic [DATA_W-1:0] r_rspData;
    logic              r_rspZero;
    logic              r_rspErr;
    logic              r_rspId;
    logic [CNT_W-1:0]  r_doneCnt [2];
    logic [DATA_W-1:0] w_aluResult;
    logic              w_aluZero;

    // A lone valid requester wins outright; on contention the round-robin pointer decides
    assign w_grant     = (req_valid == 2'b11) ? r_rr : req_valid[1];
    assign w_handshake = (r_state == IDLE) && (|req_valid);

    ALU #(.W(DATA_W)) u_alu (
        .A        (r_a),
        .B        (r_b),
        .Op       (r_op),
        .Result   (w_aluResult),
        .Zero     (w_aluZero),
        .Carry    (),
        .OverFlow (),
        .Negative ()
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    // Next-state and request-accept decode
    always_comb begin
        w_nextState = r_state;
        req_ready   = 2'b00;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready   = w_grant ? 2'b10 : 2'b01;
                    w_nextState = EXEC;
                end
            end
            EXEC:    w_nextState = RESP;
            RESP:    if (rsp_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Operand capture on handshake, result capture in EXEC, counter update on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr         <= 1'b0;
            r_op         <= OP_SUB;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_rspData    <= '0;
            r_rspZero    <= 1'b0;
            r_rspErr     <= 1'b0;
            r_rspId      <= 1'b0;
            r_doneCnt[0] <= '0;
            r_doneCnt[1] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_op <= alu_op_t'(w_grant ? req_op1 : req_op0);
                        r_a  <= w_grant ? req_a1 : req_a0;
                        r_b  <= w_grant ? req_b1 : req_b0;
                        r_id <= w_grant;
                        r_rr <= ~w_grant;
                    end
                end
                EXEC: begin
                    r_rspData <= w_aluResult;
                    r_rspZero <= w_aluZero;
                    r_rspErr  <= (r_op == OP_INV);
                    r_rspId   <= r_id;
                end
                RESP: begin
                    if (rsp_ready && (r_doneCnt[r_id] != {CNT_W{1'b1}}))
                        r_doneCnt[r_id] <= r_doneCnt[r_id] + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign rsp_data  = r_rspData;
    assign rsp_zero  = r_rspZero;
    assign rsp_err   = r_rspErr;
    assign rsp_id    = r_rspId;
    assign done_cnt0 = r_doneCnt[0];
    assign done_cnt1 = r_doneCnt[1];

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl; counters built 2 bits wide so saturation is reachable.
module tb_alu_share_ctrl;

    localparam int DW = 16;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_ready;
    logic [2:0]    req_op0 = '0, req_op1 = '0;
    logic [DW-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_id;
    logic [DW-1:0] rsp_data;
    logic          rsp_zero;
    logic          rsp_err;
    logic          busy;
    logic [CW-1:0] done_cnt0, done_cnt1;

    int checks = 0;
    int errors = 0;

    alu_share_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .done_cnt0 (done_cnt0),
        .done_cnt1 (done_cnt1)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid,
                                 input logic [2:0] op0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                                 input logic [2:0] op1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                                 input logic rdy);
        req_valid = valid;
        req_op0   = op0;
        req_a0    = a0;
        req_b0    = b0;
        req_op1   = op1;
        req_a1    = a1;
        req_b1    = b1;
        rsp_ready = rdy;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(2'b00, 3'd0, '0, '0, 3'd0, '0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Handshake in cycle N, EXEC in N+1, response visible in N+2 with rsp_ready high
    task automatic issueOp(input string tag, input logic [1:0] valid,
                           input logic [2:0] op0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                           input logic [2:0] op1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                           input logic [1:0] expReady, input logic expId, input logic [DW-1:0] expData,
                           input logic expZero, input logic expErr);
        @(negedge clk);
        applyStimulus(valid, op0, a0, b0, op1, a1, b1, 1'b1);
        #1;
        checkOutput({tag, "_grant"}, 32'(req_ready), 32'(expReady));
        @(negedge clk);
        #1;
        checkOutput({tag, "_exec_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({tag, "_rsp_id"}, 32'(rsp_id), 32'(expId));
        checkOutput({tag, "_rsp_data"}, 32'(rsp_data), 32'(expData));
        checkOutput({tag, "_rsp_zero"}, 32'(rsp_zero), 32'(expZero));
        checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'(expErr));
    endtask

    initial begin
        // Reset values
        doReset();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_cnt0", 32'(done_cnt0), 32'd0);
        checkOutput("rst_cnt1", 32'(done_cnt1), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);

        // Single ADD from requester 0: 5 + 3 = 8
        issueOp("single", 2'b01, 3'b001, 16'h0005, 16'h0003, 3'b000, '0, '0,
                2'b01, 1'b0, 16'h0008, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(2'b00, 3'd0, '0, '0, 3'd0, '0, '0, 1'b1);
        #1;
        checkOutput("single_idle_busy", 32'(busy), 32'd0);
        checkOutput("single_idle_valid", 32'(rsp_valid), 32'd0);
        checkOutput("single_cnt0", 32'(done_cnt0), 32'd1);
        checkOutput("single_cnt1", 32'(done_cnt1), 32'd0);

        // Contention: both valid every cycle, grants alternate starting with requester 0
        doReset();
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                issueOp("contend0", 2'b11, 3'b000, 16'd7, 16'd7, 3'b010, 16'd3, 16'd4,
                        2'b01, 1'b0, 16'h0000, 1'b1, 1'b0);
            else
                issueOp("contend1", 2'b11, 3'b000, 16'd7, 16'd7, 3'b010, 16'd3, 16'd4,
                        2'b10, 1'b1, 16'h000C, 1'b0, 1'b0);
        end
        @(negedge clk);
        applyStimulus(2'b00, 3'd0, '0, '0, 3'd0, '0, '0, 1'b1);
        #1;
        checkOutput("contend_cnt0", 32'(done_cnt0), 32'd2);
        checkOutput("contend_cnt1", 32'(done_cnt1), 32'd2);

        // Backpressure: requester 1 AND, response held for 5 cycles
        doReset();
        @(negedge clk);
        applyStimulus(2'b10, 3'd0, '0, '0, 3'b100, 16'h00F0, 16'h0FF0, 1'b0);
        #1;
        checkOutput("bp_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        applyStimulus(2'b11, 3'b001, 16'h1111, 16'h2222, 3'b001, 16'h3333, 16'h4444, 1'b0);
        #1;
        checkOutput("bp_exec_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput("bp_hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_hold_data", 32'(rsp_data), 32'h00F0);
            checkOutput("bp_hold_id", 32'(rsp_id), 32'd1);
            checkOutput("bp_hold_ready", 32'(req_ready), 32'd0);
            checkOutput("bp_hold_cnt1", 32'(done_cnt1), 32'd0);
        end
        @(negedge clk);
        applyStimulus(2'b00, 3'd0, '0, '0, 3'd0, '0, '0, 1'b1);
        #1;
        checkOutput("bp_accept_valid", 32'(rsp_valid), 32'd1);
        checkOutput("bp_accept_data", 32'(rsp_data), 32'h00F0);
        @(negedge clk);
        #1;
        checkOutput("bp_done_valid", 32'(rsp_valid), 32'd0);
        checkOutput("bp_done_busy", 32'(busy), 32'd0);
        checkOutput("bp_done_cnt1", 32'(done_cnt1), 32'd1);

        // Unsupported op still completes, with zero result and error flag
        doReset();
        issueOp("inv", 2'b01, 3'b111, 16'h1234, 16'h0001, 3'd0, '0, '0,
                2'b01, 1'b0, 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(2'b00, 3'd0, '0, '0, 3'd0, '0, '0, 1'b1);
        #1;
        checkOutput("inv_cnt0", 32'(done_cnt0), 32'd1);

        // Reset while in RESP: pointer currently favours requester 1
        @(negedge clk);
        applyStimulus(2'b01, 3'b001, 16'd1, 16'd1, 3'd0, '0, '0, 1'b0);
        #1;
        checkOutput("rresp_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        applyStimulus(2'b00, 3'd0, '0, '0, 3'd0, '0, '0, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("rresp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rresp_data", 32'(rsp_data), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rresp_after_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rresp_after_busy", 32'(busy), 32'd0);
        checkOutput("rresp_after_cnt0", 32'(done_cnt0), 32'd0);
        checkOutput("rresp_after_cnt1", 32'(done_cnt1), 32'd0);
        checkOutput("rresp_after_data", 32'(rsp_data), 32'd0);
        applyStimulus(2'b11, 3'd0, '0, '0, 3'd0, '0, '0, 1'b0);
        #1;
        checkOutput("rresp_rr_zero", 32'(req_ready), 32'h1);

        // Saturation: four SHR ops from requester 1 with a 2-bit counter
        doReset();
        for (int i = 0; i < 4; i++) begin
            issueOp("sat", 2'b10, 3'd0, '0, '0, 3'b110, 16'h0010, 16'h0000,
                    2'b10, 1'b1, 16'h0008, 1'b0, 1'b0);
            @(negedge clk);
            applyStimulus(2'b00, 3'd0, '0, '0, 3'd0, '0, '0, 1'b1);
            #1;
            checkOutput("sat_cnt1", 32'(done_cnt1), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        checkOutput("sat_cnt0", 32'(done_cnt0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Round-robin controller that shares one 16-bit `ALU` instance between two requesters. Each requester has a valid/ready request channel. The controller grants one request at a time, registers the operands, and drives the ALU. It captures the ALU result and returns it on a single tagged response channel with backpressure. It also keeps per-requester saturating completion counters for debug readout.

## Interface
- `DATA_W`, 16: operand/result width; must match the ALU datapath.
- `CNT_W`, 16: width of each completion counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  per-requester request valid; bit i belongs to requester i.
- `req_ready`  out  2  per-requester accept; at most one bit high per cycle.
- `req_op0`, `req_op1`  in  3 each  ALU operation code.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  DATA_W each  operands.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer accept.
- `rsp_id`  out  1  requester index the response belongs to.
- `rsp_data`  out  DATA_W  registered ALU result.
- `rsp_zero`  out  1  registered ALU Zero flag (result == 0).
- `rsp_err`  out  1  high when the op code was 3'b111, which is unsupported.
- `busy`  out  1  high in every state except IDLE.
- `done_cnt0`, `done_cnt1`  out  CNT_W  completed-response counts per requester.

## Operation
- Op codes: 000 sub, 001 add, 010 mul, 011 A/3, 100 and, 101 shl A, 110 shr A, 111 unsupported (ALU returns 0).
- The FSM has three states: IDLE, EXEC, RESP. Reset forces IDLE.
- **IDLE:**
  - Grant is combinational from `req_valid` and the round-robin pointer `rr`, where `rr` names the preferred requester.
  - If both requesters are valid, grant `rr`. If only one is valid, grant that one.
  - `req_ready[g]` = 1 only for the granted requester g.
  - On handshake (`req_valid[g] & req_ready[g]`):
    - latch op, A, B and id = g;
    - set `rr` to ~g;
    - go to EXEC.
- **EXEC:**
  - The latched operands drive the ALU.
  - `rsp_data`, `rsp_zero`, `rsp_id` and `rsp_err` (= latched op == 3'b111) are registered.
  - Go to RESP.
- **RESP:**
  - `rsp_valid` = 1, and response fields are held stable.
  - When `rsp_ready` = 1: increment `done_cnt[id]` (saturating at all-ones, no wrap) and go to IDLE.
  - Otherwise stay in RESP indefinitely.
- Only one operation is in flight at a time. `req_ready` is 0 in EXEC and RESP.
- Requester inputs are sampled only on the handshake cycle. Later changes to them do not affect the in-flight op.
- Unsupported ops are still accepted and responded to: `rsp_data` = 0, `rsp_zero` = 1, `rsp_err` = 1.

## Timing
- Reset values:
  - state IDLE, `rr` = 0;
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `rsp_zero` = 0, `rsp_err` = 0;
  - `busy` = 0, both counters = 0.
  - `req_ready` in the reset cycle follows the IDLE grant rule.
- Latency: a handshake in cycle N gives `rsp_valid` = 1 from cycle N+2.
- Back-to-back throughput: if `rsp_ready` is held high, the response completes in N+2, IDLE is reached in N+3, and the next handshake can occur in N+3. That is one op per 3 cycles.
- Reset mid-operation (EXEC or RESP): the op is dropped without a response, the counters clear, and the FSM is in IDLE next cycle.
- `rsp_valid` never drops without `rsp_ready`, except on `rst`.
- A counter increments only on the `rsp_valid & rsp_ready` cycle.

## Structure
- A shared package `alu_pkg` holds:
  - the `alu_op_t` enum: OP_SUB, OP_ADD, OP_MUL, OP_DIV3, OP_AND, OP_SHL, OP_SHR, OP_INV;
  - the `ctrl_state_t` enum: IDLE, EXEC, RESP;
  - `DATA_W`.
- Exactly one sub-module: the existing `ALU`, instantiated once. Its Carry, OverFlow and Negative outputs are left unconnected.
- Grant logic and counters stay inline; no further sub-modules.

## Test plan
- Single op, req0: op=001, A=0x0005, B=0x0003, `rsp_ready` = 1. Response at N+2: `rsp_data` = 0x0008, `rsp_id` = 0, `rsp_zero` = 0, `done_cnt0` = 1.
- Contention: both valid every cycle, req0 op=000 A=7 B=7, req1 op=010 A=3 B=4. Grants alternate 0,1,0,1. Responses: 0x0000 with `rsp_zero` = 1, then 0x000C.
- Backpressure: `rsp_ready` = 0 for 5 cycles after `rsp_valid`. The response is held stable, `req_ready` = 2'b00 throughout, and the counter is unchanged until accept.
- Unsupported op: op=111, A=0x1234. Expect `rsp_data` = 0, `rsp_zero` = 1, `rsp_err` = 1, and the counter increments.
- Reset in RESP: assert `rst` for one cycle while `rsp_valid` = 1. Next cycle `rsp_valid` = 0, `busy` = 0, counters = 0, and `rr` = 0.
- Saturation: with `CNT_W` = 2, four req1 ops give `done_cnt1` = 3 and no wrap.
